// File: rtl/uart_tx_arbiter_if.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter_if
// Bundles the byte-producer handshakes, the uart_tx drive/status lines and the
// FIFO status of uart_tx_arbiter.
//   cli_valid/cli_data/cli_ready    : CLI byte handshake
//   cip_valid/cip_index/cip_ready   : cipher letter-index handshake
//   group_clear                     : 1-cycle pulse restarting the 5-letter grouping
//   tx_start/tx_din                 : one start pulse plus byte towards uart_tx
//   tx_active/tx_done               : uart_tx busy level and end-of-byte pulse
//   fifo_level/overflow             : FIFO occupancy and sticky overflow flag
// Modports: slave = the arbiter itself, master = producers and uart_tx side.
// -----------------------------------------------------------------------------
interface uart_tx_arbiter_if #(
    parameter int DEPTH = 16
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic          cli_valid;
    logic [7:0]    cli_data;
    logic          cli_ready;
    logic          cip_valid;
    logic [4:0]    cip_index;
    logic          cip_ready;
    logic          group_clear;
    logic          tx_start;
    logic [7:0]    tx_din;
    logic          tx_active;
    logic          tx_done;
    logic [LW-1:0] fifo_level;
    logic          overflow;

    modport slave (
        input  cli_valid, cli_data, cip_valid, cip_index, group_clear,
        input  tx_active, tx_done,
        output cli_ready, cip_ready, tx_start, tx_din, fifo_level, overflow
    );

    modport master (
        output cli_valid, cli_data, cip_valid, cip_index, group_clear,
        output tx_active, tx_done,
        input  cli_ready, cip_ready, tx_start, tx_din, fifo_level, overflow
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
// Merges CLI text/echo bytes and Enigma cipher letters into one ordered FIFO and
// is the single driver of tx_start/tx_din towards uart_tx. Cipher indices are
// turned into ASCII ('A'+idx, '?' for idx>25) and, when GROUP_LEN>0, a space is
// inserted after every GROUP_LEN letters.
// Ports:
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   bus    : uart_tx_arbiter_if.slave (handshakes, uart_tx lines, FIFO status)
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int DEPTH     = 16,
    parameter int GROUP_LEN = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    uart_tx_arbiter_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int GW = (GROUP_LEN > 0) ? $clog2(GROUP_LEN + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_BUSY = 2'd1,
        ST_WAIT_DONE = 2'd2
    } state_t;

    logic [7:0]    mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [LW-1:0] level_r;
    logic [LW-1:0] level_nxt_s;
    logic          full_r;
    logic          empty_r;
    logic          overflow_r;
    logic [GW-1:0] gcnt_r;
    state_t        state_r;
    state_t        state_nxt_s;
    logic          tx_start_r;
    logic [7:0]    tx_din_r;

    logic          insert_space_s;
    logic          cli_ready_s;
    logic          cip_ready_s;
    logic          cli_acc_s;
    logic          cip_acc_s;
    logic          space_wr_s;
    logic          push_s;
    logic          pop_s;
    logic          ovf_event_s;
    logic [7:0]    wr_data_s;

    // Letter index to ASCII; out-of-range indices become '?'.
    function automatic logic [7:0] to_ascii(input logic [4:0] idx);
        if (idx > 5'd25) begin
            return 8'h3F;
        end else begin
            return 8'h41 + {3'b000, idx};
        end
    endfunction

    // Write arbitration: CLI first, then a pending group space, then the cipher letter.
    // Readies are forced low while rst_n is asserted.
    always_comb begin
        insert_space_s = 1'b0;
        if (GROUP_LEN > 0) begin
            insert_space_s = bus.cip_valid && (gcnt_r == GW'(GROUP_LEN));
        end else begin
            insert_space_s = 1'b0;
        end
        cli_ready_s = rst_n && !full_r;
        cip_ready_s = rst_n && !full_r && !bus.cli_valid && !insert_space_s;
        cli_acc_s   = bus.cli_valid && cli_ready_s;
        cip_acc_s   = bus.cip_valid && cip_ready_s;
        // The space occupies the write slot of a cycle in which the letter is held off.
        space_wr_s  = rst_n && insert_space_s && !full_r && !bus.cli_valid;
        push_s      = cli_acc_s || cip_acc_s || space_wr_s;
        ovf_event_s = (bus.cli_valid || bus.cip_valid) && full_r;
        if (cli_acc_s) begin
            wr_data_s = bus.cli_data;
        end else if (space_wr_s) begin
            wr_data_s = 8'h20;
        end else if (cip_acc_s) begin
            wr_data_s = to_ascii(bus.cip_index);
        end else begin
            wr_data_s = 8'h00;
        end
    end

    // Next occupancy from this cycle's push/pop pair.
    always_comb begin
        case ({push_s, pop_s})
            2'b10:   level_nxt_s = level_r + LW'(1);
            2'b01:   level_nxt_s = level_r - LW'(1);
            default: level_nxt_s = level_r;
        endcase
    end

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wr_data_s;
        end
    end

    // FIFO pointers, registered level/full/empty and sticky overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            level_r    <= '0;
            full_r     <= 1'b0;
            empty_r    <= 1'b1;
            overflow_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            level_r <= level_nxt_s;
            full_r  <= (level_nxt_s == LW'(DEPTH));
            empty_r <= (level_nxt_s == LW'(0));
            if (ovf_event_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // Group counter: clear pulse beats everything, CLI bytes and spaces restart the group.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gcnt_r <= '0;
        end else if (bus.group_clear || cli_acc_s || space_wr_s) begin
            gcnt_r <= '0;
        end else if (cip_acc_s && (gcnt_r < GW'(GROUP_LEN))) begin
            gcnt_r <= gcnt_r + GW'(1);
        end
    end

    // Read FSM next state and pop decision.
    always_comb begin
        state_nxt_s = state_r;
        pop_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!empty_r && !bus.tx_active) begin
                    pop_s       = 1'b1;
                    state_nxt_s = ST_WAIT_BUSY;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT_BUSY: begin
                // A done pulse ends the byte even if busy was never seen high.
                if (bus.tx_done) begin
                    state_nxt_s = ST_IDLE;
                end else if (bus.tx_active) begin
                    state_nxt_s = ST_WAIT_DONE;
                end else begin
                    state_nxt_s = ST_WAIT_BUSY;
                end
            end
            ST_WAIT_DONE: begin
                if (bus.tx_done) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_WAIT_DONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM state plus registered tx_start pulse and held tx_din.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            tx_start_r <= 1'b0;
            tx_din_r   <= 8'h00;
        end else begin
            state_r    <= state_nxt_s;
            tx_start_r <= pop_s;
            if (pop_s) begin
                tx_din_r <= mem_r[rd_ptr_r];
            end
        end
    end

    assign bus.cli_ready  = cli_ready_s;
    assign bus.cip_ready  = cip_ready_s;
    assign bus.tx_start   = tx_start_r;
    assign bus.tx_din     = tx_din_r;
    assign bus.fifo_level = level_r;
    assign bus.overflow   = overflow_r;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Directed bench for uart_tx_arbiter. Expected bytes go into a scoreboard queue
// when stimulus is accepted; a small uart_tx model pops and compares on every
// tx_start and answers with tx_active/tx_done.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;
    localparam int DEPTH     = 16;
    localparam int GROUP_LEN = 5;
    localparam int BUSY_CYC  = 6;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.DEPTH(DEPTH)) bus ();

    logic model_busy = 1'b0;
    logic hold_busy  = 1'b0;
    assign bus.tx_active = model_busy | hold_busy;

    uart_tx_arbiter #(.DEPTH(DEPTH), .GROUP_LEN(GROUP_LEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int start_cnt = 0;
    int tb_gcnt = 0;
    logic [7:0] exp_q [$];
    logic [7:0] rx_log [$];
    int         start_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // uart_tx model: scoreboard check on each start, then busy, then a done pulse.
    initial begin
        logic [7:0] din_hold;
        bus.tx_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && bus.tx_start) begin
                start_cnt++;
                start_q.push_back(cyc);
                rx_log.push_back(bus.tx_din);
                tests++;
                assert (exp_q.size() != 0) else begin
                    fails++;
                    $error("FAIL unexpected_start observed=%0h expected=none", bus.tx_din);
                end
                if (exp_q.size() != 0) check("tx_byte", bus.tx_din, exp_q.pop_front());
                din_hold   = bus.tx_din;
                model_busy = 1'b1;
                for (int i = 0; i < BUSY_CYC; i++) begin
                    @(negedge clk);
                    if (!rst_n) break;
                    check("start_single", bus.tx_start, 1'b0);
                    check("din_stable", bus.tx_din, din_hold);
                end
                if (rst_n) begin
                    bus.tx_done = 1'b1;
                    model_busy  = 1'b0;
                    @(negedge clk);
                    bus.tx_done = 1'b0;
                end else begin
                    model_busy = 1'b0;
                end
            end
        end
    end

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || model_busy || bus.tx_done) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            tests++;
            fails++;
            $error("FAIL drain_timeout observed=%0d expected=0", exp_q.size());
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic cli_send(input logic [7:0] d);
        int n = 0;
        bus.cli_valid = 1'b1;
        bus.cli_data  = d;
        #1;
        while (!bus.cli_ready && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 200) begin
            tests++;
            fails++;
            $error("FAIL cli_timeout observed=stall expected=accept");
        end else begin
            exp_q.push_back(d);
            tb_gcnt = 0;
        end
        @(negedge clk);
    endtask

    task automatic cip_send(input logic [4:0] idx);
        int n = 0;
        bus.cip_valid = 1'b1;
        bus.cip_index = idx;
        if (tb_gcnt == GROUP_LEN) begin
            exp_q.push_back(8'h20);
            tb_gcnt = 0;
        end
        #1;
        while (!bus.cip_ready && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 200) begin
            tests++;
            fails++;
            $error("FAIL cip_timeout observed=stall expected=accept");
        end else begin
            exp_q.push_back((idx > 5'd25) ? 8'h3F : (8'h41 + {3'b000, idx}));
            tb_gcnt++;
        end
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] menu [4];
        string exp4;
        string exp6;
        int acc_cyc;
        int base;
        menu = '{8'h4D, 8'h45, 8'h4E, 8'h55};
        exp4 = "ABCDE FGHIJ KL";
        exp6 = "?AB C";
        bus.cli_valid   = 1'b0;
        bus.cli_data    = 8'h00;
        bus.cip_valid   = 1'b0;
        bus.cip_index   = 5'd0;
        bus.group_clear = 1'b0;
        rst_n = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_tx_start", bus.tx_start, 1'b0);
        check("rst_tx_din", bus.tx_din, 8'h00);
        check("rst_level", bus.fifo_level, 5'd0);
        check("rst_overflow", bus.overflow, 1'b0);
        check("rst_cli_ready", bus.cli_ready, 1'b0);
        check("rst_cip_ready", bus.cip_ready, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // T2: CLI order and latency
        start_q.delete();
        rx_log.delete();
        base    = start_cnt;
        acc_cyc = cyc;
        for (int i = 0; i < 4; i++) cli_send(menu[i]);
        bus.cli_valid = 1'b0;
        drain();
        check("t2_starts", start_cnt - base, 4);
        check("t2_latency", start_q[0] - acc_cyc, 2);
        for (int i = 0; i < 4; i++) check("t2_byte", rx_log[i], menu[i]);

        // T3: CLI priority over cipher
        rx_log.delete();
        bus.cli_valid = 1'b1;
        bus.cli_data  = 8'h3E;
        bus.cip_valid = 1'b1;
        bus.cip_index = 5'd2;
        #1;
        check("t3_cip_ready", bus.cip_ready, 1'b0);
        check("t3_cli_ready", bus.cli_ready, 1'b1);
        exp_q.push_back(8'h3E);
        tb_gcnt = 0;
        @(negedge clk);
        bus.cli_valid = 1'b0;
        cip_send(5'd2);
        bus.cip_valid = 1'b0;
        drain();
        check("t3_first", rx_log[0], 8'h3E);
        check("t3_second", rx_log[1], 8'h43);

        // T4: grouping into 5-letter groups
        rx_log.delete();
        bus.group_clear = 1'b1;
        @(negedge clk);
        bus.group_clear = 1'b0;
        tb_gcnt = 0;
        for (int i = 0; i < 12; i++) cip_send(5'(i));
        bus.cip_valid = 1'b0;
        drain();
        check("t4_len", rx_log.size(), exp4.len());
        for (int i = 0; i < exp4.len(); i++) check("t4_char", rx_log[i], exp4[i]);

        // T6: bad index gives '?' and counts toward the group
        rx_log.delete();
        cip_send(5'd27);
        cip_send(5'd0);
        cip_send(5'd1);
        cip_send(5'd2);
        bus.cip_valid = 1'b0;
        drain();
        check("t6_len", rx_log.size(), exp6.len());
        for (int i = 0; i < exp6.len(); i++) check("t6_char", rx_log[i], exp6[i]);

        // T5: full and overflow with the line held busy
        hold_busy = 1'b1;
        repeat (2) @(negedge clk);
        base = start_cnt;
        for (int i = 0; i < 16; i++) cli_send(8'h60 + 8'(i));
        bus.cli_data = 8'h7F;
        #1;
        check("t5_cli_ready_full", bus.cli_ready, 1'b0);
        check("t5_cip_ready_full", bus.cip_ready, 1'b0);
        check("t5_level_full", bus.fifo_level, 5'd16);
        @(negedge clk);
        #1;
        check("t5_overflow", bus.overflow, 1'b1);
        check("t5_level_after", bus.fifo_level, 5'd16);
        bus.cli_valid = 1'b0;
        check("t5_no_start", start_cnt - base, 0);
        @(negedge clk);
        hold_busy = 1'b0;
        drain();
        check("t5_sent", start_cnt - base, 16);
        check("t5_overflow_sticky", bus.overflow, 1'b1);
        check("t5_level_empty", bus.fifo_level, 5'd0);

        // T1: reset mid-transfer with 3 bytes queued
        for (int i = 0; i < 4; i++) cli_send(8'h30 + 8'(i));
        bus.cli_valid = 1'b0;
        #1;
        check("t1_level_queued", bus.fifo_level, 5'd3);
        rst_n = 1'b0;
        #1;
        check("t1_tx_start", bus.tx_start, 1'b0);
        check("t1_level", bus.fifo_level, 5'd0);
        check("t1_overflow", bus.overflow, 1'b0);
        check("t1_tx_din", bus.tx_din, 8'h00);
        check("t1_cli_ready", bus.cli_ready, 1'b0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        base = start_cnt;
        repeat (40) @(negedge clk);
        check("t1_nothing_sent", start_cnt - base, 0);
        check("t1_level_after", bus.fifo_level, 5'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
